// File: rtl/bless_inject_ctrl_pkg.sv
// rtl/bless_inject_ctrl_pkg.sv - shared widths, slot classification and popcount for the injection controller
package bless_inject_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SEQ_FIELD_W = 8;
  localparam int NET_PORTS   = 4;
  localparam int NUM_PORTS   = NET_PORTS + 1;

  typedef enum logic [1:0] {
    SLOT_FREE      = 2'd0,
    SLOT_BLOCKED   = 2'd1,
    SLOT_THROTTLED = 2'd2
  } slot_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/bless_inject_ctrl_if.sv
// rtl/bless_inject_ctrl_if.sv - PE/network/router signal bundle of the injection controller
interface bless_inject_ctrl_if
  import bless_inject_ctrl_pkg::*;
#(
  parameter int FLIT_W = DATA_WIDTH,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pe_valid;
  logic              pe_ready;
  logic [FLIT_W-1:0] pe_flit;
  logic [3:0]        nb_valid;
  logic              throttle;
  logic              inj_valid;
  logic [FLIT_W-1:0] inj_flit;
  logic              starve;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output pe_valid, pe_flit, nb_valid, throttle,
    input  pe_ready, inj_valid, inj_flit, starve, occupancy
  );

  modport slave (
    input  pe_valid, pe_flit, nb_valid, throttle,
    output pe_ready, inj_valid, inj_flit, starve, occupancy
  );

endinterface

// File: rtl/bless_inject_ctrl_inj_fifo.sv
// rtl/bless_inject_ctrl_inj_fifo.sv - synchronous injection FIFO with fill counter
module inj_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bless_inject_ctrl.sv
// rtl/bless_inject_ctrl.sv - BLESS local-port injection scheduler with seq stamping and starvation flag
module bless_inject_ctrl
  import bless_inject_ctrl_pkg::*;
#(
  parameter int FLIT_W     = DATA_WIDTH,
  parameter int SEQ_W      = SEQ_FIELD_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 16
) (
  input logic                clk,
  input logic                reset,
  bless_inject_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BLK_W = $clog2(STARVE_LIM + 1);

  logic [FLIT_W-1:0] head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [2:0]        nb_cnt;
  slot_e             slot;
  logic              push;
  logic              pop;
  logic [SEQ_W-1:0]  seq;
  logic [BLK_W-1:0]  blk_cnt;
  logic [BLK_W-1:0]  blk_next;
  logic              inj_valid_q;
  logic [FLIT_W-1:0] inj_flit_q;
  logic              starve_q;
  logic [FLIT_W-1:0] stamped;

  always_comb begin
    nb_cnt = popcount4(bus.nb_valid);
    if (bus.throttle) begin
      slot = SLOT_THROTTLED;
    end else if (nb_cnt == 3'd4) begin
      slot = SLOT_BLOCKED;
    end else begin
      slot = SLOT_FREE;
    end
  end

  // pe_ready looks only at registered fullness, never at this cycle's pop.
  assign push = bus.pe_valid && !full;
  assign pop  = !empty && (slot == SLOT_FREE);

  assign stamped = {seq, head[FLIT_W-SEQ_W-1:0]};

  always_comb begin
    blk_next = blk_cnt;
    if (empty || pop) begin
      blk_next = '0;
    end else if (slot == SLOT_BLOCKED && blk_cnt != BLK_W'(STARVE_LIM)) begin
      blk_next = blk_cnt + BLK_W'(1);
    end
  end

  inj_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.pe_flit),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_valid_q <= 1'b0;
      inj_flit_q  <= '0;
      seq         <= '0;
      blk_cnt     <= '0;
      starve_q    <= 1'b0;
    end else begin
      inj_valid_q <= pop;
      inj_flit_q  <= pop ? stamped : '0;
      if (pop) begin
        seq <= seq + SEQ_W'(1);
      end
      blk_cnt  <= blk_next;
      starve_q <= (blk_next >= BLK_W'(STARVE_LIM));
    end
  end

  assign bus.pe_ready  = !full;
  assign bus.occupancy = count;
  assign bus.inj_valid = inj_valid_q;
  assign bus.inj_flit  = inj_flit_q;
  assign bus.starve    = starve_q;

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// tb/tb_bless_inject_ctrl.sv - directed self-checking bench for bless_inject_ctrl
module tb_bless_inject_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bless_inject_ctrl_if #(.FLIT_W(32), .DEPTH(4)) bus ();

  bless_inject_ctrl #(
    .FLIT_W     (32),
    .SEQ_W      (8),
    .DEPTH      (4),
    .STARVE_LIM (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] junk, input logic [23:0] pay);
    return {junk, pay};
  endfunction

  function automatic logic [31:0] ex(input logic [7:0] sq, input logic [23:0] pay);
    return {sq, pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pe_valid = 1'b0;
    bus.pe_flit  = '0;
    bus.nb_valid = 4'b0000;
    bus.throttle = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pe_valid = 1'b1;
    bus.pe_flit  = 32'hDEADBEEF;
    bus.nb_valid = 4'b0000;
    bus.throttle = 1'b0;
    tick();
    tick();
    tick();
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", bus.occupancy); end
    total++; if (bus.inj_valid !== 1'b0) begin bad++; $display("FAIL reset_inj_valid got=%b want=0", bus.inj_valid); end
    total++; if (bus.inj_flit !== 32'h0) begin bad++; $display("FAIL reset_inj_flit got=%h want=0", bus.inj_flit); end
    total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL reset_starve got=%b want=0", bus.starve); end
    reset = 1'b0;
    #1;
    total++; if (bus.pe_ready !== 1'b1) begin bad++; $display("FAIL reset_pe_ready got=%b want=1", bus.pe_ready); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_release_occ got=%0d want=0", bus.occupancy); end
    bus.pe_valid = 1'b0;
  endtask

  task automatic test_idle_network();
    do_reset();
    bus.pe_valid = 1'b1;
    bus.pe_flit  = mk(8'hFF, 24'h0000A1);
    tick();
    total++; if (bus.inj_valid !== 1'b0) begin bad++; $display("FAIL idle_lat1 got=%b want=0", bus.inj_valid); end
    bus.pe_flit = mk(8'h77, 24'h0000B2);
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd0, 24'h0000A1)) begin
      bad++; $display("FAIL idle_A got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd0, 24'h0000A1));
    end
    bus.pe_flit = mk(8'h12, 24'h0000C3);
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd1, 24'h0000B2)) begin
      bad++; $display("FAIL idle_B got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd1, 24'h0000B2));
    end
    bus.pe_valid = 1'b0;
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd2, 24'h0000C3)) begin
      bad++; $display("FAIL idle_C got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd2, 24'h0000C3));
    end
    tick();
    total++; if (bus.inj_valid !== 1'b0 || bus.inj_flit !== 32'h0 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL idle_end got=%b/%h/%0d want=0/0/0", bus.inj_valid, bus.inj_flit, bus.occupancy);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    bus.nb_valid = 4'b1111;
    bus.pe_valid = 1'b1;
    bus.pe_flit  = mk(8'h00, 24'h00_5A5A);
    tick();
    bus.pe_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL starve_at15 got=%b want=0", bus.starve); end
    tick();
    total++; if (bus.starve !== 1'b1) begin bad++; $display("FAIL starve_at16 got=%b want=1", bus.starve); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.starve !== 1'b1 || bus.inj_valid !== 1'b0 || bus.occupancy !== 3'd1) begin
      bad++; $display("FAIL starve_hold got=%b/%b/%0d want=1/0/1", bus.starve, bus.inj_valid, bus.occupancy);
    end
    bus.nb_valid = 4'b0111;
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd0, 24'h00_5A5A)) begin
      bad++; $display("FAIL starve_inject got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd0, 24'h00_5A5A));
    end
    total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL starve_clear got=%b want=0", bus.starve); end
    bus.nb_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.nb_valid = 4'b1111;
    bus.pe_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pe_flit = mk(8'hEE, 24'(i + 16'h0100));
      tick();
    end
    bus.pe_flit = mk(8'hEE, 24'h000104);
    total++; if (bus.occupancy !== 3'd4 || bus.pe_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full got=%0d/%b want=4/0", bus.occupancy, bus.pe_ready);
    end
    tick();
    total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL bp_reject got=%0d want=4", bus.occupancy); end
    bus.nb_valid = 4'b0111;
    tick();
    total++; if (bus.occupancy !== 3'd3 || bus.inj_flit !== ex(8'd0, 24'h000100)) begin
      bad++; $display("FAIL bp_pop_at_full got=%0d/%h want=3/%h", bus.occupancy, bus.inj_flit, ex(8'd0, 24'h000100));
    end
    bus.nb_valid = 4'b1111;
    tick();
    total++; if (bus.occupancy !== 3'd4 || bus.pe_ready !== 1'b0) begin
      bad++; $display("FAIL bp_refill got=%0d/%b want=4/0", bus.occupancy, bus.pe_ready);
    end
    bus.pe_valid = 1'b0;
    bus.nb_valid = 4'b0111;
    tick();
    bus.pe_valid = 1'b1;
    bus.pe_flit  = mk(8'hEE, 24'h000105);
    tick();
    total++; if (bus.occupancy !== 3'd3 || bus.inj_flit !== ex(8'd2, 24'h000102)) begin
      bad++; $display("FAIL bp_push_pop got=%0d/%h want=3/%h", bus.occupancy, bus.inj_flit, ex(8'd2, 24'h000102));
    end
    bus.pe_valid = 1'b0;
    for (int i = 3; i < 6; i++) begin
      tick();
      total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'(i), 24'(i + 16'h0100))) begin
        bad++; $display("FAIL bp_drain%0d got=%b/%h want=1/%h", i, bus.inj_valid, bus.inj_flit, ex(8'(i), 24'(i + 16'h0100)));
      end
    end
    bus.nb_valid = 4'b0000;
  endtask

  task automatic test_throttle();
    logic saw_inj;
    logic saw_starve;
    do_reset();
    bus.throttle = 1'b1;
    bus.pe_valid = 1'b1;
    bus.pe_flit  = mk(8'h01, 24'h00AAAA);
    tick();
    bus.pe_flit  = mk(8'h02, 24'h00BBBB);
    tick();
    bus.pe_valid = 1'b0;
    saw_inj    = 1'b0;
    saw_starve = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw_inj    = saw_inj | bus.inj_valid;
      saw_starve = saw_starve | bus.starve;
    end
    total++; if (saw_inj !== 1'b0 || saw_starve !== 1'b0 || bus.occupancy !== 3'd2) begin
      bad++; $display("FAIL thr_hold got=%b/%b/%0d want=0/0/2", saw_inj, saw_starve, bus.occupancy);
    end
    bus.throttle = 1'b0;
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd0, 24'h00AAAA)) begin
      bad++; $display("FAIL thr_first got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd0, 24'h00AAAA));
    end
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd1, 24'h00BBBB)) begin
      bad++; $display("FAIL thr_second got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd1, 24'h00BBBB));
    end
  endtask

  task automatic test_seq_wrap_and_reset();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i <= 257; i++) begin
      bus.pe_valid = (i < 257);
      bus.pe_flit  = mk(8'hC3, 24'(i));
      tick();
      if (i >= 1) begin
        if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'(i - 1), 24'(i - 1))) begin
          errs++;
          if (errs < 4) $display("FAIL wrap_stream%0d got=%b/%h want=1/%h", i - 1, bus.inj_valid, bus.inj_flit, ex(8'(i - 1), 24'(i - 1)));
        end
      end
      if (i == 257) begin
        total++; if (bus.inj_flit !== ex(8'h00, 24'd256)) begin
          bad++; $display("FAIL wrap_flit256 got=%h want=%h", bus.inj_flit, ex(8'h00, 24'd256));
        end
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL wrap_stream got=%0d_errors want=0", errs); end
    bus.pe_valid = 1'b1;
    bus.nb_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      bus.pe_flit = mk(8'h00, 24'(24'h300 + i));
      tick();
    end
    bus.pe_valid = 1'b0;
    bus.nb_valid = 4'b0000;
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd1, 24'h000300)) begin
      bad++; $display("FAIL midburst_inject got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd1, 24'h000300));
    end
    reset = 1'b1;
    #1;
    total++; if (bus.inj_valid !== 1'b0 || bus.inj_flit !== 32'h0 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL midburst_reset got=%b/%h/%0d want=0/0/0", bus.inj_valid, bus.inj_flit, bus.occupancy);
    end
    tick();
    reset = 1'b0;
    bus.pe_valid = 1'b1;
    bus.pe_flit  = mk(8'h99, 24'h000777);
    tick();
    bus.pe_valid = 1'b0;
    tick();
    total++; if (bus.inj_valid !== 1'b1 || bus.inj_flit !== ex(8'd0, 24'h000777)) begin
      bad++; $display("FAIL seq_restart got=%b/%h want=1/%h", bus.inj_valid, bus.inj_flit, ex(8'd0, 24'h000777));
    end
    tick();
    total++; if (bus.inj_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL seq_restart_end got=%b/%0d want=0/0", bus.inj_valid, bus.occupancy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_idle_network();
    test_starvation();
    test_backpressure();
    test_throttle();
    test_seq_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
